// File: rtl/mem_bist_if.sv
// Valid/ready request bus between the BIST master and the memory.
// The master drives the request fields; the memory returns read data and ready.
interface mem_bist_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_rd;
  logic [WIDTH-1:0]      w_data;
  logic                  valid;
  logic [WIDTH-1:0]      r_data;
  logic                  ready;

  modport master (
    output addr, wr_rd, w_data, valid,
    input  r_data, ready
  );

  modport slave (
    input  addr, wr_rd, w_data, valid,
    output r_data, ready
  );
endinterface

// File: rtl/mem_bist_master.sv
// Write-then-read pattern sweep over the memory with pass/fail reporting.
// Define MEM_BIST_TIMEOUT_EN to abort a sweep after TIMEOUT stalled cycles.
module mem_bist_master #(
  parameter int          WIDTH      = 16,
  parameter int          DEPTH      = 16,
  parameter int          ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [15:0] SEED       = 16'hA5C3
`ifdef MEM_BIST_TIMEOUT_EN
  , parameter int        TIMEOUT    = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0]      fail_data,
  output logic                  timeout,
  mem_bist_if.master            bus
);

  localparam logic [WIDTH-1:0]      SEED_W  = WIDTH'(SEED);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_rd_q;
  logic [WIDTH-1:0]      w_data_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [ADDR_WIDTH:0]   err_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [WIDTH-1:0]      fail_data_q;
  logic                  timeout_q;

  logic                  last;
  logic                  mism;
  logic [ADDR_WIDTH:0]   err_d;
  logic                  stall_hit;

  function automatic logic [WIDTH-1:0] pat(
    input logic [ADDR_WIDTH-1:0] i
  );
    return SEED_W + WIDTH'(i);
  endfunction

  assign last  = (addr_q == LAST);
  assign mism  = (bus.r_data != pat(addr_q));
  assign err_d = (mism && err_q != ERR_MAX)
               ? err_q + 1'b1 : err_q;

`ifdef MEM_BIST_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q;

  assign stall_hit = valid_q && !bus.ready
                  && stall_q == SW'(TIMEOUT - 1);

  // Counts consecutive stalled cycles of the current request.
  always_ff @(posedge clk) begin
    if (rst || !valid_q || bus.ready) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_rd_q     <= 1'b0;
      w_data_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= WRITE;
            addr_q      <= '0;
            wr_rd_q     <= 1'b1;
            w_data_q    <= SEED_W;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            timeout_q   <= 1'b0;
          end
        end
        WRITE: begin
          if (stall_hit) begin
            state_q   <= DONE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (bus.ready) begin
            if (last) begin
              state_q  <= READ;
              addr_q   <= '0;
              wr_rd_q  <= 1'b0;
              w_data_q <= '0;
            end else begin
              addr_q   <= addr_q + 1'b1;
              w_data_q <= pat(addr_q + 1'b1);
            end
          end
        end
        READ: begin
          if (stall_hit) begin
            state_q   <= DONE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (bus.ready) begin
            err_q <= err_d;
            // Only the first miscompare is recorded.
            if (mism && err_q == '0) begin
              fail_addr_q <= addr_q;
              fail_data_q <= bus.r_data;
            end
            if (last) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.addr   = addr_q;
  assign bus.wr_rd  = wr_rd_q;
  assign bus.w_data = w_data_q;
  assign bus.valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed and randomized sweeps of mem_bist_master against a faulty memory model.
// Expected results come from the pattern rule and the injected fault masks.
module tb_mem_bist_master;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam logic [15:0] SEED = 16'hA5C3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, pass, timeout;
  logic [AW:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic [W-1:0]  fail_data;

  mem_bist_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_bist_master dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .timeout   (timeout),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mem  [D];
  logic [W-1:0] flip [D];
  logic [W-1:0] stuck0 = '0;

  assign bus.r_data = (mem[bus.addr] ^ flip[bus.addr]) & ~stuck0;

  int stall_lo = 0, stall_hi = 0, left = 0;
  int hold_addr = -1, hold_len = 0;
  bit vld_prev = 1'b0;

  // Ready generator: random stall count per request, optional long hold.
  always @(negedge clk) begin
    if (bus.ready === 1'b1 && vld_prev)
      left = $urandom_range(stall_hi, stall_lo);
    if (hold_len > 0 && bus.valid && bus.wr_rd
        && int'(bus.addr) == hold_addr) begin
      bus.ready = 1'b0;
      hold_len--;
    end else if (left > 0) begin
      bus.ready = 1'b0;
      if (bus.valid) left--;
    end else begin
      bus.ready = 1'b1;
    end
    vld_prev = bus.valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } xfer_t;

  xfer_t q[$];
  int    stalls = 0;
  int    done_cnt = 0;
  bit    held = 1'b0;
  xfer_t snap;

  // Transfer log, memory write port and request-stability check.
  always @(posedge clk) begin
    if (rst !== 1'b0) begin
      held = 1'b0;
    end else begin
      if (held && !timeout)
        chk("stable", {bus.wr_rd, bus.addr, bus.w_data}, snap);
      held = 1'b0;
      if (bus.valid && bus.ready) begin
        q.push_back({bus.wr_rd, bus.addr,
                     bus.wr_rd ? bus.w_data : '0});
        if (bus.wr_rd) mem[bus.addr] <= bus.w_data;
      end else if (bus.valid) begin
        stalls++;
        held = 1'b1;
        snap = {bus.wr_rd, bus.addr, bus.w_data};
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [W-1:0] pat(input int i);
    return W'(SEED + i);
  endfunction

  function automatic logic [W-1:0] rd_model(input int i);
    return (pat(i) ^ flip[i]) & ~stuck0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".err"}, err_count, 0);
    chk({tag, ".faddr"}, fail_addr, 0);
    chk({tag, ".fdata"}, fail_data, 0);
    chk({tag, ".tmo"}, timeout, 0);
    chk({tag, ".valid"}, bus.valid, 0);
    chk({tag, ".addr"}, bus.addr, 0);
    chk({tag, ".wr_rd"}, bus.wr_rd, 0);
    chk({tag, ".wdata"}, bus.w_data, 0);
  endtask

  task automatic run_sweep(input string tag, output int k);
    q.delete();
    stalls = 0;
    left = $urandom_range(stall_hi, stall_lo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy1"}, busy, 1);
    chk({tag, ".valid1"}, bus.valid, 1);
    k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".done"}, done, 1);
  endtask

  task automatic check_results(input string tag, input int k);
    int e = 0;
    int fa = 0;
    logic [W-1:0] fd = '0;
    logic [W-1:0] r;
    xfer_t ex;
    for (int i = 0; i < D; i++) begin
      r = rd_model(i);
      if (r != pat(i)) begin
        if (e == 0) begin
          fa = i;
          fd = r;
        end
        e++;
      end
    end
    if (e > D) e = D;
    chk({tag, ".pass"}, pass, (e == 0));
    chk({tag, ".err"}, err_count, e);
    chk({tag, ".faddr"}, fail_addr, fa);
    chk({tag, ".fdata"}, fail_data, fd);
    chk({tag, ".tmo"}, timeout, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".valid"}, bus.valid, 0);
    chk({tag, ".lat"}, k, 2 * D + stalls);
    chk({tag, ".nxfer"}, q.size(), 2 * D);
    for (int i = 0; i < q.size() && i < 2 * D; i++) begin
      if (i < D) ex = {1'b1, AW'(i), pat(i)};
      else       ex = {1'b0, AW'(i - D), W'(0)};
      chk({tag, ".xfer"}, q[i], ex);
    end
    @(negedge clk);
    chk({tag, ".pulse"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".hold"}, pass, (e == 0));
    chk({tag, ".herr"}, err_count, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int a;
    int n;
    int dc;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < D; i++) flip[i] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_sweep("ideal", k);
    check_results("ideal", k);
    chk("ideal.lat0", k, 2 * D);
    repeat (5) @(negedge clk);
    chk("ideal.persist", pass, 1);

    flip[5] = 16'h0001;
    run_sweep("flip5", k);
    start = 1'b1;
    check_results("flip5", k);
    start = 1'b0;
    chk("flip5.fdata_c", fail_data, 16'hA5C9);
    chk("flip5.faddr_c", fail_addr, 5);
    flip[5] = '0;

    stuck0 = 16'h8000;
    run_sweep("stuck15", k);
    check_results("stuck15", k);
    chk("stuck15.err_c", err_count, 16);
    chk("stuck15.fdata_c", fail_data, 16'h25C3);
    stuck0 = '0;

    stall_lo = 3;
    stall_hi = 3;
    run_sweep("stall3", k);
    check_results("stall3", k);
    chk("stall3.stalls", stalls, 3 * 2 * D);

    for (int it = 0; it < 4; it++) begin
      stall_lo = 0;
      stall_hi = $urandom_range(3);
      for (int i = 0; i < D; i++)
        flip[i] = ($urandom_range(3) == 0)
                ? W'($urandom_range(16'hFFFF, 1)) : '0;
      run_sweep("rand", k);
      check_results("rand", k);
    end
    for (int i = 0; i < D; i++) flip[i] = '0;
    stall_lo = 0;
    stall_hi = 0;
    left = 0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = int'(bus.addr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("repulse.addr", bus.addr, a + 1);
    chk("repulse.wr", bus.wr_rd, 1);
    n = 0;
    while (!(bus.valid && !bus.wr_rd && bus.addr == 7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid.reach", bus.addr, 7);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    chk("rst_mid.nodone", done_cnt, dc);
    chk("rst_mid.novalid", bus.valid, 0);
    run_sweep("after_rst", k);
    check_results("after_rst", k);

    hold_addr = 3;
`ifdef MEM_BIST_TIMEOUT_EN
    hold_len = 1000;
    run_sweep("tmo", k);
    chk("tmo.flag", timeout, 1);
    chk("tmo.pass", pass, 0);
    chk("tmo.valid", bus.valid, 0);
    chk("tmo.busy", busy, 0);
    chk("tmo.stalls", stalls, 64);
    chk("tmo.lat", k, 3 + 64);
    chk("tmo.nxfer", q.size(), 3);
    @(negedge clk);
    chk("tmo.pulse", done, 0);
    chk("tmo.hold", timeout, 1);
    hold_len = 0;
    run_sweep("post_tmo", k);
    check_results("post_tmo", k);
`else
    hold_len = 80;
    run_sweep("longstall", k);
    check_results("longstall", k);
    chk("longstall.stalls", stalls, 80);
    hold_len = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
